// File: rtl/wor_line_monitor.sv
// wor_line_monitor
//   Consumer of the shared wired-OR request line. Synchronises the raw line,
//   debounces it into a clean level, emits one-cycle rise/fall strobes,
//   counts debounced rises (saturating) and flags a line held high too long.
//   Optional feature macro: WOR_MON_STUCK_EN builds the stuck detector;
//   without it the stuck output is tied low and no stuck counter exists.
module wor_line_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 8,
    parameter int STUCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_in,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             stuck
);

    // deb_cnt only needs to hold 0..DEB_CYCLES-1
    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0]    DEB_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                s;
    logic [DW-1:0]       deb_cnt;
    logic [DW-1:0]       deb_cnt_next;
    logic                enter_high;
    logic                enter_low;
    logic                level_next;
    logic [CNT_W-1:0]    pulse_cnt_next;

    // Synchroniser chain; only the last stage is ever looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOW;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a level change needs DEB_CYCLES equal samples in a row
    always_comb begin
        state_next = state;
        case (state)
            LOW: begin
                if (s) state_next = RISE_CHK;
            end
            RISE_CHK: begin
                if (!s)                       state_next = LOW;
                else if (deb_cnt == DEB_LAST) state_next = HIGH;
            end
            HIGH: begin
                if (!s) state_next = FALL_CHK;
            end
            FALL_CHK: begin
                if (s)                        state_next = HIGH;
                else if (deb_cnt == DEB_LAST) state_next = LOW;
            end
            default: state_next = LOW;
        endcase
    end

    // Output/datapath decode: debounce counter and the two level-change events
    always_comb begin
        deb_cnt_next = deb_cnt;
        enter_high   = 1'b0;
        enter_low    = 1'b0;
        case (state)
            LOW: begin
                if (s) deb_cnt_next = DEB_ONE;
            end
            RISE_CHK: begin
                if (!s) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt_next = '0;
                    enter_high   = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + DEB_ONE;
                end
            end
            HIGH: begin
                if (!s) deb_cnt_next = DEB_ONE;
            end
            FALL_CHK: begin
                if (s) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt_next = '0;
                    enter_low    = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + DEB_ONE;
                end
            end
            default: deb_cnt_next = '0;
        endcase
    end

    // Level follows the debounced events; a rise with clr in the same cycle restarts the count at 1
    always_comb begin
        level_next = level;
        if (enter_high)     level_next = 1'b1;
        else if (enter_low) level_next = 1'b0;

        pulse_cnt_next = pulse_cnt;
        if (enter_high) begin
            if (clr)                    pulse_cnt_next = CNT_ONE;
            else if (pulse_cnt != CNT_MAX) pulse_cnt_next = pulse_cnt + CNT_ONE;
        end else if (clr) begin
            pulse_cnt_next = '0;
        end
    end

    // Registered outputs and debounce counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            deb_cnt   <= deb_cnt_next;
            level     <= level_next;
            rise      <= enter_high;
            fall      <= enter_low;
            pulse_cnt <= pulse_cnt_next;
        end
    end

`ifdef WOR_MON_STUCK_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_PRE = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_ONE = SW'(1);

    logic          hold_high;
    logic [SW-1:0] stuck_cnt;
    logic [SW-1:0] stuck_cnt_next;
    logic          stuck_set;

    // Time spent high only accrues in HIGH proper, not while a fall is being qualified
    assign hold_high = (state == HIGH) && s;

    // Saturating high-time counter; stuck fires on the cycle it reaches the limit
    always_comb begin
        stuck_cnt_next = stuck_cnt;
        stuck_set      = 1'b0;
        if (enter_low) begin
            stuck_cnt_next = '0;
        end else if (hold_high && (stuck_cnt != STUCK_MAX)) begin
            stuck_cnt_next = stuck_cnt + STUCK_ONE;
            stuck_set      = (stuck_cnt == STUCK_PRE);
        end
    end

    // Sticky flag: a set in the same cycle as clr takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else begin
            stuck_cnt <= stuck_cnt_next;
            if (stuck_set)  stuck <= 1'b1;
            else if (clr)   stuck <= 1'b0;
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_wor_line_monitor.sv
// Bench for wor_line_monitor: directed stimulus, a cycle-by-cycle behavioural
// model (delay line + run-length debounce) checked every cycle, and literal
// expectations at the points where the timing is known by hand.
module tb_wor_line_monitor;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int STK  = 16;
    localparam int CMAX = (1 << CW) - 1;

`ifdef WOR_MON_STUCK_EN
    localparam bit STUCK_ON = 1'b1;
`else
    localparam bit STUCK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          line_in = 1'b0;
    logic          clr = 1'b0;
    logic          level;
    logic          rise;
    logic          fall;
    logic [CW-1:0] pulse_cnt;
    logic          stuck;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise   = 0;
    int n_fall   = 0;

    always #5 clk = ~clk;

    wor_line_monitor #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .CNT_W       (CW),
        .STUCK_CYCLES(STK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_in  (line_in),
        .clr      (clr),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .pulse_cnt(pulse_cnt),
        .stuck    (stuck)
    );

    // ---------------- behavioural model ----------------
    bit lhist[$];   // raw line samples, one per edge since reset
    bit shist[$];   // synchronised samples seen by the debouncer
    bit m_level, m_rise, m_fall, m_stuck;
    int m_cnt, m_hi;
    bit s_now, s_prev, flip, hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lhist.delete();
            shist.delete();
            m_level = 0; m_rise = 0; m_fall = 0; m_stuck = 0;
            m_cnt = 0; m_hi = 0;
        end else begin
            // line seen by the debouncer is the raw line SYNC edges ago
            s_now  = (lhist.size() >= SYNC) ? lhist[lhist.size() - SYNC] : 1'b0;
            s_prev = (shist.size() > 0) ? shist[shist.size() - 1] : 1'b0;
            shist.push_back(s_now);
            lhist.push_back(line_in);
            if (lhist.size() > 32) void'(lhist.pop_front());
            if (shist.size() > 32) void'(shist.pop_front());

            // level flips once the last DEB samples all disagree with it
            flip = 0;
            if (shist.size() >= DEB) begin
                flip = 1;
                for (int i = 1; i <= DEB; i++)
                    if (shist[shist.size() - i] == m_level) flip = 0;
            end
            m_rise = flip && !m_level;
            m_fall = flip && m_level;

            // high time: counts while level is high and the line stayed high
            hold = m_level && s_now && s_prev;
            if (m_fall) begin
                m_hi = 0;
            end else if (hold && m_hi < STK) begin
                m_hi++;
                if (STUCK_ON && m_hi == STK) m_stuck = 1;
                else if (clr) m_stuck = 0;
            end else if (clr) begin
                m_stuck = 0;
            end

            if (m_rise) m_cnt = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
            else if (clr) m_cnt = 0;

            if (flip) m_level = !m_level;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (level !== m_level || rise !== m_rise || fall !== m_fall ||
                pulse_cnt !== CW'(m_cnt) || stuck !== m_stuck) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t dut(level=%b rise=%b fall=%b cnt=%0d stuck=%b) model(level=%b rise=%b fall=%b cnt=%0d stuck=%b)",
                         $time, level, rise, fall, pulse_cnt, stuck,
                         m_level, m_rise, m_fall, m_cnt, m_stuck);
            end
            if (rise) n_rise++;
            if (fall) n_fall++;
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s ok: %0d", name, act);
        end
    endtask

    // drive inputs, let one edge sample them, return just after that edge
    task automatic drive(input logic li, input logic c);
        line_in = li;
        clr     = c;
        @(posedge clk);
        #2;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            repeat (hi) drive(1'b1, 1'b0);
            repeat (lo) drive(1'b0, 1'b0);
        end
    endtask

    int r0, f0;

    initial begin
        // power-on reset
        #1 rst = 1'b1;
        #1;
        lit("por_level", level, 0);
        lit("por_cnt", pulse_cnt, 0);
        lit("por_stuck", stuck, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) drive(1'b0, 1'b0);

        // 1: reset asserted mid-HIGH
        pulses(2, 10, 10);
        repeat (8) drive(1'b1, 1'b0);
        lit("t1_pre_level", level, 1);
        lit("t1_pre_cnt", pulse_cnt, 3);
        #1 rst = 1'b1;
        #1;
        lit("t1_async_level", level, 0);
        lit("t1_async_rise_fall", {rise, fall}, 0);
        lit("t1_async_cnt", pulse_cnt, 0);
        lit("t1_async_stuck", stuck, 0);
        line_in = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (6) drive(1'b0, 1'b0);
        lit("t1_post_level", level, 0);

        // 2: clean rise, long hold, clean fall
        for (int i = 1; i <= 30; i++) begin
            drive(1'b1, 1'b0);
            if (i == 5)  lit("t2_level_c5", level, 0);
            if (i == 6)  lit("t2_rise_c6", {level, rise}, 2'b11);
            if (i == 7)  lit("t2_rise_c7", rise, 0);
            if (i == 21) lit("t2_stuck_c21", stuck, 0);
            if (i == 22) lit("t2_stuck_c22", stuck, STUCK_ON);
        end
        lit("t2_cnt", pulse_cnt, 1);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0);
            if (i == 5) lit("t2_fall_c5", {level, fall}, 2'b10);
            if (i == 6) lit("t2_fall_c6", {level, fall}, 2'b01);
            if (i == 7) lit("t2_fall_c7", fall, 0);
        end
        lit("t2_stuck_kept", stuck, STUCK_ON);

        // 3: glitches shorter than the debounce window are rejected
        r0 = n_rise;
        repeat (2) drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        repeat (3) drive(1'b1, 1'b0);
        repeat (8) drive(1'b0, 1'b0);
        lit("t3_no_rise", n_rise - r0, 0);
        lit("t3_cnt", pulse_cnt, 1);
        // exactly DEB high cycles is the shortest accepted pulse
        repeat (DEB) drive(1'b1, 1'b0);
        repeat (8) drive(1'b0, 1'b0);
        lit("t3_min_pulse_rise", n_rise - r0, 1);
        lit("t3_min_pulse_cnt", pulse_cnt, 2);

        // 5: clr coinciding with a rise
        pulses(5, 10, 10);
        lit("t5_pre_cnt", pulse_cnt, 7);
        lit("t5_pre_stuck", stuck, STUCK_ON);
        for (int i = 1; i <= 6; i++) drive(1'b1, (i == 6) ? 1'b1 : 1'b0);
        lit("t5_rise", rise, 1);
        lit("t5_cnt", pulse_cnt, 1);
        lit("t5_stuck", stuck, 0);
        repeat (4) drive(1'b1, 1'b0);
        repeat (10) drive(1'b0, 1'b0);

        // 4: saturation over 300 clean pulses
        r0 = n_rise;
        f0 = n_fall;
        pulses(300, 10, 10);
        lit("t4_rises", n_rise - r0, 300);
        lit("t4_falls", n_fall - f0, 300);
        lit("t4_cnt_sat", pulse_cnt, CMAX);
        lit("t4_stuck", stuck, 0);

        // 6: long hold; stuck only when the detector is built
        repeat (100) drive(1'b1, 1'b0);
        lit("t6_level", level, 1);
        lit("t6_stuck", stuck, STUCK_ON);
        repeat (10) drive(1'b0, 1'b0);
        lit("t6_level_low", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
